// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell codes, scan directions, FSM states and
// the direction/colour helper functions used by the validator and flipper.
package othello_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] BLACK = 2'b01;
    localparam logic [1:0] WHITE = 2'b10;
    localparam logic [1:0] RSVD  = 2'b11;

    typedef enum logic [2:0] {
        DIR_N, DIR_NE, DIR_E, DIR_SE, DIR_S, DIR_SW, DIR_W, DIR_NW
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_ORIGIN, ST_DIR_INIT, ST_STEP, ST_WAIT, ST_EVAL, ST_DONE
    } state_e;

    function automatic int dir_drow(input dir_e d);
        case (d)
            DIR_N, DIR_NE, DIR_NW: return -1;
            DIR_SE, DIR_S, DIR_SW: return 1;
            default:               return 0;
        endcase
    endfunction

    function automatic int dir_dcol(input dir_e d);
        case (d)
            DIR_NE, DIR_E, DIR_SE: return 1;
            DIR_SW, DIR_W, DIR_NW: return -1;
            default:               return 0;
        endcase
    endfunction

    function automatic logic [1:0] opponent(input logic player);
        return player ? BLACK : WHITE;
    endfunction

    function automatic logic [1:0] own_cell(input logic player);
        return player ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/multi_dir_validator_if.sv
// Controller-facing request/result signals plus the board RAM read port.
interface multi_dir_validator_if #(
    parameter int BOARD_DIM = 8,
    parameter int ADDR_W    = $clog2(BOARD_DIM * BOARD_DIM),
    parameter int CNT_W     = $clog2(8 * BOARD_DIM)
);
    logic              start;
    logic [ADDR_W-1:0] s_addr_in;
    logic              player;
    logic [7:0]        dir_en;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic [1:0]        mem_q;
    logic              busy;
    logic              done;
    logic              legal;
    logic [7:0]        dir_mask;
    logic [CNT_W-1:0]  flip_count;

    modport master (
        output start, s_addr_in, player, dir_en, mem_q,
        input  mem_addr, mem_rden, busy, done, legal, dir_mask, flip_count
    );

    modport slave (
        input  start, s_addr_in, player, dir_en, mem_q,
        output mem_addr, mem_rden, busy, done, legal, dir_mask, flip_count
    );
endinterface

// File: rtl/multi_dir_validator_board_stepper.sv
// One step along a direction with row/col kept separate, so a move off the
// board is flagged instead of wrapping into the neighbouring row.
module board_stepper
    import othello_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int ADDR_W    = $clog2(BOARD_DIM * BOARD_DIM),
    parameter int RC_W      = $clog2(BOARD_DIM)
) (
    input  logic [RC_W-1:0]   row,
    input  logic [RC_W-1:0]   col,
    input  logic [2:0]        dir,
    output logic [RC_W-1:0]   next_row,
    output logic [RC_W-1:0]   next_col,
    output logic [ADDR_W-1:0] next_addr,
    output logic              off_board
);
    int r_i;
    int c_i;

    always_comb begin
        r_i       = int'(row) + dir_drow(dir_e'(dir));
        c_i       = int'(col) + dir_dcol(dir_e'(dir));
        off_board = (r_i < 0) || (r_i >= BOARD_DIM) || (c_i < 0) || (c_i >= BOARD_DIM);
        next_row  = RC_W'(r_i);
        next_col  = RC_W'(c_i);
        next_addr = ADDR_W'(r_i * BOARD_DIM + c_i);
    end
endmodule

// File: rtl/multi_dir_validator.sv
// Othello move validator: probes all eight directions from a candidate square
// and reports per-direction captures, legality and the total flip count.
module multi_dir_validator
    import othello_pkg::*;
#(
    parameter int BOARD_DIM = 8,
    parameter int ADDR_W    = $clog2(BOARD_DIM * BOARD_DIM),
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = $clog2(8 * BOARD_DIM)
) (
    input  logic                  clock,
    input  logic                  reset,
    multi_dir_validator_if.slave  bus
);
    localparam int         RC_W      = $clog2(BOARD_DIM);
    localparam int         CELLS     = BOARD_DIM * BOARD_DIM;
    localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;
    localparam state_e     AFTER_RD  = (RD_LAT > 1) ? ST_WAIT : ST_EVAL;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic              player_q, player_d;
    logic [7:0]        dir_en_q, dir_en_d;
    logic [2:0]        d_q, d_d;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [RC_W-1:0]   row_q, row_d;
    logic [RC_W-1:0]   col_q, col_d;
    logic [1:0]        wait_q, wait_d;
    logic              origin_phase_q, origin_phase_d;
    logic [7:0]        dir_mask_q, dir_mask_d;
    logic [CNT_W-1:0]  flip_count_q, flip_count_d;

    logic [RC_W-1:0]   orig_row, orig_col;
    logic [RC_W-1:0]   step_row, step_col;
    logic [RC_W-1:0]   step_row_n, step_col_n;
    logic [ADDR_W-1:0] step_addr;
    logic              step_off;
    logic              dir_end;
    logic              mem_rden_c;
    logic [ADDR_W-1:0] mem_addr_c;

    assign orig_row = RC_W'(int'(s_addr_q) / BOARD_DIM);
    assign orig_col = RC_W'(int'(s_addr_q) % BOARD_DIM);

    // DIR_INIT steps from the origin so an edge-facing direction costs one cycle.
    assign step_row = (state_q == ST_DIR_INIT) ? orig_row : row_q;
    assign step_col = (state_q == ST_DIR_INIT) ? orig_col : col_q;

    board_stepper #(
        .BOARD_DIM (BOARD_DIM),
        .ADDR_W    (ADDR_W),
        .RC_W      (RC_W)
    ) u_stepper (
        .row       (step_row),
        .col       (step_col),
        .dir       (d_q),
        .next_row  (step_row_n),
        .next_col  (step_col_n),
        .next_addr (step_addr),
        .off_board (step_off)
    );

    always_comb begin
        state_d        = state_q;
        s_addr_d       = s_addr_q;
        player_d       = player_q;
        dir_en_d       = dir_en_q;
        d_d            = d_q;
        run_d          = run_q;
        row_d          = row_q;
        col_d          = col_q;
        wait_d         = wait_q;
        origin_phase_d = origin_phase_q;
        dir_mask_d     = dir_mask_q;
        flip_count_d   = flip_count_q;
        dir_end        = 1'b0;
        mem_rden_c     = 1'b0;
        mem_addr_c     = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    s_addr_d     = bus.s_addr_in;
                    player_d     = bus.player;
                    dir_en_d     = bus.dir_en;
                    dir_mask_d   = '0;
                    flip_count_d = '0;
                    state_d      = ST_ORIGIN;
                end
            end
            ST_ORIGIN: begin
                if (int'(s_addr_q) >= CELLS) begin
                    state_d = ST_DONE;
                end else begin
                    mem_rden_c     = 1'b1;
                    mem_addr_c     = s_addr_q;
                    origin_phase_d = 1'b1;
                    wait_d         = WAIT_INIT;
                    state_d        = AFTER_RD;
                end
            end
            ST_DIR_INIT: begin
                if (!dir_en_q[d_q] || step_off) begin
                    dir_end = 1'b1;
                end else begin
                    run_d   = '0;
                    row_d   = orig_row;
                    col_d   = orig_col;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (step_off) begin
                    dir_end = 1'b1;
                end else begin
                    mem_rden_c = 1'b1;
                    mem_addr_c = step_addr;
                    row_d      = step_row_n;
                    col_d      = step_col_n;
                    wait_d     = WAIT_INIT;
                    state_d    = AFTER_RD;
                end
            end
            ST_WAIT: begin
                if (wait_q == 2'd0) state_d = ST_EVAL;
                else                wait_d  = wait_q - 2'd1;
            end
            ST_EVAL: begin
                if (origin_phase_q) begin
                    origin_phase_d = 1'b0;
                    // Reserved counts as empty here, so only a real disc blocks the move.
                    if (bus.mem_q == BLACK || bus.mem_q == WHITE) begin
                        state_d = ST_DONE;
                    end else begin
                        d_d     = 3'd0;
                        state_d = ST_DIR_INIT;
                    end
                end else if (bus.mem_q == opponent(player_q)) begin
                    run_d   = run_q + 1'b1;
                    state_d = ST_STEP;
                end else begin
                    if (bus.mem_q == own_cell(player_q) && run_q != '0) begin
                        dir_mask_d[d_q] = 1'b1;
                        flip_count_d    = flip_count_q + run_q;
                    end
                    dir_end = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (dir_end) begin
            if (d_q == 3'd7) begin
                state_d = ST_DONE;
            end else begin
                d_d     = d_q + 3'd1;
                state_d = ST_DIR_INIT;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            s_addr_q       <= '0;
            player_q       <= 1'b0;
            dir_en_q       <= '0;
            d_q            <= '0;
            run_q          <= '0;
            row_q          <= '0;
            col_q          <= '0;
            wait_q         <= '0;
            origin_phase_q <= 1'b0;
            dir_mask_q     <= '0;
            flip_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            s_addr_q       <= s_addr_d;
            player_q       <= player_d;
            dir_en_q       <= dir_en_d;
            d_q            <= d_d;
            run_q          <= run_d;
            row_q          <= row_d;
            col_q          <= col_d;
            wait_q         <= wait_d;
            origin_phase_q <= origin_phase_d;
            dir_mask_q     <= dir_mask_d;
            flip_count_q   <= flip_count_d;
        end
    end

    assign bus.mem_rden   = mem_rden_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.legal      = |dir_mask_q;
    assign bus.dir_mask   = dir_mask_q;
    assign bus.flip_count = flip_count_q;
endmodule
